alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Downstream consumer of the 32-bit ALU (aluc-coded; r, zero, carry, negative, overflow outputs). It sits between the execute and writeback stages.
- Accepts one ALU result per valid/ready handshake. Merges only the flags that the opcode defines into a persistent status word (PSW). Buffers result plus PSW snapshot in a small FIFO skid buffer.
- Presents entries in order to the register-file writeback port.

Parameters:
WIDTH, 32, datapath width of r / out_r
DEPTH, 2, buffer entries (>=2, any integer; pointers wrap at DEPTH-1)
DEST_W, 5, destination register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  ALU result valid
in_ready  out  1  stage can accept
aluc  in  4  opcode that produced the result
r  in  WIDTH  ALU result
zero  in  1  ALU zero flag
carry  in  1  ALU carry flag
negative  in  1  ALU negative flag
overflow  in  1  ALU overflow flag
dest  in  DEST_W  destination register index
out_valid  out  1  head entry valid
out_ready  in  1  writeback consumes head
out_r  out  WIDTH  head result
out_dest  out  DEST_W  head destination
out_psw  out  4  head PSW snapshot {N,V,C,Z}
psw  out  4  live PSW {N,V,C,Z}
sticky_ov  out  1  set by any accepted overflow=1 on ADD/SUB
clr_sticky  in  1  clears sticky_ov

Behaviour:
- Reset (async, rst=1), all values hold while rst is high:
  - count=0, pointers=0, psw=0, sticky_ov=0
  - out_valid=0, out_r=0, out_dest=0, out_psw=0
  - in_ready=1
- Accept: push = in_valid & in_ready. Pop: pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It is driven from registered count only, with no combinational path from out_ready.
- Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle) if the buffer was empty. Otherwise it appears in FIFO order.
- out_valid = (count != 0). out_* show the head entry. When empty, out_r, out_dest and out_psw read 0.
- Push and pop in the same cycle:
  - count is unchanged; both pointers advance.
  - When full, push cannot occur (in_ready=0), so only the pop happens.
- Flag merge on push. Per-opcode update mask: Z and N are updated for every opcode; C and V per the list below. Unmasked PSW bits keep their prior value.
  - 0000 ADDU, 0001 SUBU: Z N C
  - 0010 ADD, 0011 SUB: Z N V
  - 0100-0111 AND/OR/XOR/NOR: Z N
  - 1000, 1001 LUI: Z N
  - 1010 SLTU: Z N C
  - 1011 SLT: Z N
  - 1100-1111 SRA/SRL/SLL: Z N C
- psw updates at the push edge. The entry stores the post-merge PSW as out_psw.
- No push: psw holds; input flags are ignored.
- sticky_ov:
  - Sets on push when aluc in {0010, 0011} and overflow=1.
  - clr_sticky clears it.
  - Simultaneous set and clear in one cycle: set wins.
- Back-to-back pushes: each merge uses the psw already updated by the previous edge.
- Reset mid-operation: buffered entries are discarded and PSW is lost. The upstream producer must reissue.
- Width: r is stored unmodified. No sign or zero extension occurs in this stage.

Decomposition:
- Shared package alu_pkg:
  - aluc opcode constants (ALU_ADDU ... ALU_SLL)
  - PSW bit indices (PSW_Z=0, PSW_C=1, PSW_V=2, PSW_N=3)
  - WIDTH default
  - flag_mask(aluc) function returning a 4-bit update mask
- One sub-module, alu_flag_merge: combinational; inputs aluc, flags, old psw; outputs new psw and overflow-event. The top level holds the FIFO storage, pointers, count and sticky logic.

Test Plan:
1. Reset then idle: assert rst mid-cycle with 1 entry buffered -> out_valid=0, psw=0000, in_ready=1 immediately, without waiting for a clock edge.
2. ADDU r=0, carry=1, zero=1, out_ready=1 -> next cycle out_valid=1, out_r=0, out_psw=0011 {N=0,V=0,C=1,Z=1}. Then AND r=0x80000000 -> psw=1010 (C retained, Z cleared).
3. ADD with overflow=1, then SUB with overflow=0 -> psw.V goes 1 then 0; sticky_ov stays 1. Assert clr_sticky in the same cycle as another ADD overflow -> sticky_ov remains 1.
4. Backpressure: out_ready=0, push 3 results (0x11, 0x22, 0x33) with DEPTH=2 -> in_ready=0 after 2 pushes and the third is held. Release out_ready -> out_r order is 0x11, 0x22, 0x33 with no loss or duplication.
5. Full-rate streaming: in_valid=1 and out_ready=1 for 16 cycles with incrementing r -> one output per cycle, in_ready never drops, count stays at 1.
6. SLT after SUBU(carry=1), with input carry=0 on SLT -> psw.C stays 1. Then SLL with carry=0 -> psw.C=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : alu_pkg
// Brief   : Opcode constants, PSW bit layout and per-opcode flag update mask.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef logic [3:0] psw_t;

  localparam logic [3:0] ALU_ADDU    = 4'b0000;
  localparam logic [3:0] ALU_SUBU    = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0011;
  localparam logic [3:0] ALU_AND     = 4'b0100;
  localparam logic [3:0] ALU_OR      = 4'b0101;
  localparam logic [3:0] ALU_XOR     = 4'b0110;
  localparam logic [3:0] ALU_NOR     = 4'b0111;
  localparam logic [3:0] ALU_LUI     = 4'b1000;
  localparam logic [3:0] ALU_LUI_ALT = 4'b1001;
  localparam logic [3:0] ALU_SLTU    = 4'b1010;
  localparam logic [3:0] ALU_SLT     = 4'b1011;
  localparam logic [3:0] ALU_SRA     = 4'b1100;
  localparam logic [3:0] ALU_SRL     = 4'b1101;
  localparam logic [3:0] ALU_SLL     = 4'b1110;
  localparam logic [3:0] ALU_SLL_ALT = 4'b1111;

  localparam int PSW_Z = 0;
  localparam int PSW_C = 1;
  localparam int PSW_V = 2;
  localparam int PSW_N = 3;

  // Z and N are always defined; C only for unsigned/shift ops, V only for signed add/sub.
  function automatic psw_t flag_mask(input logic [3:0] aluc);
    psw_t m;
    m        = '0;
    m[PSW_Z] = 1'b1;
    m[PSW_N] = 1'b1;
    case (aluc)
      ALU_ADDU, ALU_SUBU, ALU_SLTU,
      ALU_SRA, ALU_SRL, ALU_SLL, ALU_SLL_ALT: m[PSW_C] = 1'b1;
      ALU_ADD, ALU_SUB:                       m[PSW_V] = 1'b1;
      default:                                m = m;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_flag_merge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : alu_flag_merge
// Brief   : Merges opcode-defined ALU flags into the PSW; flags signed overflow.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module alu_flag_merge
  import alu_pkg::*;
(
  input  logic [3:0] aluc_i,
  input  logic       zero_i,
  input  logic       carry_i,
  input  logic       negative_i,
  input  logic       overflow_i,
  input  psw_t       psw_old_i,
  output psw_t       psw_new_o,
  output logic       ov_event_o
);

  psw_t flags;
  psw_t mask;

  always_comb begin
    flags        = '0;
    flags[PSW_Z] = zero_i;
    flags[PSW_C] = carry_i;
    flags[PSW_V] = overflow_i;
    flags[PSW_N] = negative_i;
    mask         = flag_mask(aluc_i);
    psw_new_o    = (psw_old_i & ~mask) | (flags & mask);
    ov_event_o   = overflow_i && ((aluc_i == ALU_ADD) || (aluc_i == ALU_SUB));
  end

endmodule
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : alu_wb_stage
// Brief   : ALU result skid FIFO with PSW merge and sticky overflow for writeback.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = 2,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        aluc,
  input  logic [WIDTH-1:0]  r,
  input  logic              zero,
  input  logic              carry,
  input  logic              negative,
  input  logic              overflow,
  input  logic [DEST_W-1:0] dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_r,
  output logic [DEST_W-1:0] out_dest,
  output logic [3:0]        out_psw,
  output logic [3:0]        psw,
  output logic              sticky_ov,
  input  logic              clr_sticky
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  psw_t              psw_q, psw_d;
  logic              sticky_q, sticky_d;
  psw_t              psw_merged;
  logic              ov_event;
  logic              push, pop;

  logic [WIDTH-1:0]  r_mem    [DEPTH];
  logic [DEST_W-1:0] dest_mem [DEPTH];
  psw_t              psw_mem  [DEPTH];

  alu_flag_merge u_flag_merge (
    .aluc_i     (aluc),
    .zero_i     (zero),
    .carry_i    (carry),
    .negative_i (negative),
    .overflow_i (overflow),
    .psw_old_i  (psw_q),
    .psw_new_o  (psw_merged),
    .ov_event_o (ov_event)
  );

  // in_ready depends on registered count only, keeping out_ready off the upstream path.
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    psw_d    = psw_q;
    sticky_d = sticky_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      psw_d    = psw_merged;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    // A new overflow event outranks a same-cycle clear.
    if (push && ov_event) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      psw_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      psw_q    <= psw_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[wr_ptr_q]    <= r;
      dest_mem[wr_ptr_q] <= dest;
      psw_mem[wr_ptr_q]  <= psw_merged;
    end
  end

  assign out_r     = out_valid ? r_mem[rd_ptr_q]    : '0;
  assign out_dest  = out_valid ? dest_mem[rd_ptr_q] : '0;
  assign out_psw   = out_valid ? psw_mem[rd_ptr_q]  : '0;
  assign psw       = psw_q;
  assign sticky_ov = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_alu_wb_stage
// Brief   : Directed self-checking bench for alu_wb_stage (DEPTH=2).
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_alu_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluc;
  logic [31:0] r;
  logic        zero, carry, negative, overflow;
  logic [4:0]  dest;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic [4:0]  out_dest;
  logic [3:0]  out_psw;
  logic [3:0]  psw;
  logic        sticky_ov;
  logic        clr_sticky;

  int n_cmp;
  int n_err;

  alu_wb_stage #(.WIDTH(32), .DEPTH(2), .DEST_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aluc       (aluc),
    .r          (r),
    .zero       (zero),
    .carry      (carry),
    .negative   (negative),
    .overflow   (overflow),
    .dest       (dest),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_dest   (out_dest),
    .out_psw    (out_psw),
    .psw        (psw),
    .sticky_ov  (sticky_ov),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rv,
                       input logic z, input logic c, input logic n, input logic o,
                       input logic [4:0] d);
    in_valid = v;
    aluc     = op;
    r        = rv;
    zero     = z;
    carry    = c;
    negative = n;
    overflow = o;
    dest     = d;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1 rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_psw",       {28'b0, psw},       32'h0);
    chk("rst_sticky",    {31'b0, sticky_ov}, 32'd0);
    chk("rst_out_r",     out_r,              32'h0);
    chk("rst_out_psw",   {28'b0, out_psw},   32'h0);
    rst = 1'b0;
    step();

    // ADDU r=0 Z=1 C=1, then AND 0x80000000 N=1 (C retained)
    out_ready = 1'b1;
    drive(1'b1, 4'b0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3);
    step();
    chk("addu_out_valid", {31'b0, out_valid}, 32'd1);
    chk("addu_out_r",     out_r,              32'h0);
    chk("addu_out_dest",  {27'b0, out_dest},  32'd3);
    chk("addu_out_psw",   {28'b0, out_psw},   32'b0011);
    drive(1'b1, 4'b0100, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
    step();
    chk("and_out_r",   out_r,            32'h8000_0000);
    chk("and_psw",     {28'b0, psw},     32'b1010);
    chk("and_out_psw", {28'b0, out_psw}, 32'b1010);
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_out_r",     out_r,              32'h0);
    chk("idle_psw_hold",   {28'b0, psw},       32'b1010);

    // ADD ov=1 (carry input ignored), SUB ov=0, set-vs-clear, ADDU ov ignored
    drive(1'b1, 4'b0010, 32'h7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    step();
    chk("add_ov_psw",    {28'b0, psw},       32'b0110);
    chk("add_ov_sticky", {31'b0, sticky_ov}, 32'd1);
    drive(1'b1, 4'b0011, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6);
    step();
    chk("sub_psw",    {28'b0, psw},       32'b0011);
    chk("sub_sticky", {31'b0, sticky_ov}, 32'd1);
    clr_sticky = 1'b1;
    drive(1'b1, 4'b0010, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
    step();
    chk("set_beats_clr_sticky", {31'b0, sticky_ov}, 32'd1);
    chk("set_beats_clr_psw",    {28'b0, psw},       32'b0110);
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    chk("clr_sticky", {31'b0, sticky_ov}, 32'd0);
    clr_sticky = 1'b0;
    drive(1'b1, 4'b0000, 32'h9, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8);
    step();
    chk("addu_ov_no_sticky", {31'b0, sticky_ov}, 32'd0);
    chk("addu_ov_psw",       {28'b0, psw},       32'b0100);
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();

    // Backpressure with DEPTH=2
    out_ready = 1'b0;
    drive(1'b1, 4'b0000, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
    step();
    chk("bp1_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp1_out_r",    out_r,             32'h11);
    drive(1'b1, 4'b0000, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
    step();
    chk("bp2_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp2_out_r",    out_r,             32'h11);
    drive(1'b1, 4'b0000, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
    step();
    chk("bp3_held_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp3_held_out_r",    out_r,             32'h11);
    chk("bp3_held_out_dest", {27'b0, out_dest}, 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_pop1_out_r",    out_r,             32'h22);
    chk("bp_pop1_out_dest", {27'b0, out_dest}, 32'd2);
    chk("bp_pop1_in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk("bp_pop2_out_r",    out_r,             32'h33);
    chk("bp_pop2_out_dest", {27'b0, out_dest}, 32'd3);
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    chk("bp_empty_out_valid", {31'b0, out_valid}, 32'd0);

    // Full-rate streaming
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'b0000, 32'd100 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 5'(i));
      step();
      chk("stream_out_r",     out_r,              32'd100 + 32'(i));
      chk("stream_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_in_ready",  {31'b0, in_ready},  32'd1);
    end
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();
    chk("stream_end_out_valid", {31'b0, out_valid}, 32'd0);

    // SUBU C=1 N=1, SLT keeps C, SLL clears C
    drive(1'b1, 4'b0001, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9);
    step();
    chk("subu_psw", {28'b0, psw}, 32'b1110);
    drive(1'b1, 4'b1011, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd10);
    step();
    chk("slt_psw",     {28'b0, psw},     32'b0111);
    chk("slt_out_psw", {28'b0, out_psw}, 32'b0111);
    drive(1'b1, 4'b1110, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 5'd11);
    step();
    chk("sll_psw",     {28'b0, psw},     32'b0100);
    chk("sll_out_r",   out_r,            32'h4);
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step();

    // Asynchronous reset with one entry buffered
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 32'hABCD, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12);
    step();
    drive(1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    chk("pre_rst_psw",       {28'b0, psw},       32'b1100);
    chk("pre_rst_sticky",    {31'b0, sticky_ov}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_psw",       {28'b0, psw},       32'h0);
    chk("async_rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("async_rst_sticky",    {31'b0, sticky_ov}, 32'd0);
    chk("async_rst_out_r",     out_r,              32'h0);
    step();
    chk("rst_hold_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
